// File: rtl/seq_pattern_detector_pkg.sv
// Shared types and sizing helpers for the serial pattern detector.
package seq_det_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } det_state_t;

    // Width needed to hold a fill count of 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_pattern_detector_edge.sv
// Enable-gated sample register with one-cycle rise/fall pulses on the sampled line.
module edge_detect_en (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    input  logic a,
    output logic rise,
    output logic fall
);

    logic a_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else if (clr) begin
            a_q  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else if (en) begin
            rise <= a & ~a_q;
            fall <= ~a & a_q;
            a_q  <= a;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: shift history, fill tracking, match FSM and saturating match count.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no samples collected since reset/clr or a non-overlap match
// FILL  | 0 < fill < PAT_W, history not yet long enough to compare
// HUNT  | fill == PAT_W, pattern compared on every enabled edge
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               clr,
    input  logic               overlap,
    input  logic               a,
    output logic               match,
    output logic               rise,
    output logic               fall,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [STATE_W-1:0] state
);

    localparam int                FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // Only the newest PAT_W-1 samples are needed; the current a completes the window.
    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    det_state_t        st;

    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_n;
    logic              hit;

    always_comb begin
        hist_n = {hist, a};
        fill_n = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        hit    = (fill_n == FILL_FULL) && (hist_n == PATTERN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist      <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            st        <= IDLE;
        end else if (clr) begin
            hist      <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            st        <= IDLE;
        end else if (en) begin
            hist  <= hist_n[PAT_W-2:0];
            match <= hit;
            if (hit && match_cnt != '1)
                match_cnt <= match_cnt + CNT_W'(1);
            if (hit && !overlap) begin
                fill <= '0;
                st   <= IDLE;
            end else begin
                fill <= fill_n;
                st   <= (fill_n == FILL_FULL) ? HUNT : FILL;
            end
        end else begin
            match <= 1'b0;
        end
    end

    assign state = st;

    edge_detect_en u_edge (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .clr  (clr),
        .a    (a),
        .rise (rise),
        .fall (fall)
    );

endmodule
